// File: rtl/reg32_wr_arbiter.sv
// Two-port register-file write scheduler with round-robin arbitration, status (r28) and PC (r31) sequencing.
// Optional: define REGARB_PC_GUARD_EN to restrict PC writes to requester 0 and add the pc_err output.
module reg32_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDRSIZE = 5,
  parameter int ST_ADDR  = 28,
  parameter int PC_ADDR  = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDRSIZE-1:0] req_addr,
  input  logic [NREQ*32-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     st_req,
  input  logic [31:0]              st_data,
  input  logic                     pc_step,
  input  logic                     halt,
  input  logic                     flush,
  output logic [1:0]               write,
  output logic [ADDRSIZE-1:0]      wa0,
  output logic [ADDRSIZE-1:0]      wa1,
  output logic [31:0]              wd0,
  output logic [31:0]              wd1,
  output logic                     stwr,
  output logic [31:0]              stin,
  output logic                     pcincr,
  output logic                     pc_drop,
`ifdef REGARB_PC_GUARD_EN
  output logic                     pc_err,
`endif
  output logic                     busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [ADDRSIZE-1:0] ST_A = ADDRSIZE'(ST_ADDR);
  localparam logic [ADDRSIZE-1:0] PC_A = ADDRSIZE'(PC_ADDR);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [ADDRSIZE-1:0]   addr [NREQ];
  logic [31:0]           data [NREQ];
  logic [PW-1:0]         order [NREQ];
  logic [NREQ-1:0]       elig;
  logic                  active;
  logic                  p0_vld, p1_vld, p0_bad, p1_bad;
  logic [PW-1:0]         p0_idx, p1_idx, last_idx;
  logic                  wen0, wen1, pc_hit;

  // Unpack requesters and build the rotated scan order starting at rr_ptr.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [PW:0] sum;
      assign addr[gi]  = req_addr[gi*ADDRSIZE +: ADDRSIZE];
      assign data[gi]  = req_data[gi*32 +: 32];
      assign elig[gi]  = req[gi] && !(st_req && (addr[gi] == ST_A));
      assign sum       = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
      assign order[gi] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (flush) state_next = DRAIN; else if (halt) state_next = HALT;
      DRAIN:   if (!flush) state_next = halt ? HALT : RUN;
      HALT:    if (flush) state_next = DRAIN; else if (!halt) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Grants follow the state being entered, so a flush/halt cycle grants nothing
  // and the first cycle after they drop grants immediately.
  assign active = rst && (state_next == RUN);

  always_comb begin
    p0_vld = 1'b0;
    p1_vld = 1'b0;
    p0_idx = '0;
    p1_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (elig[order[k]]) begin
        if (!p0_vld) begin
          p0_vld = 1'b1;
          p0_idx = order[k];
        end else if (!p1_vld && (addr[order[k]] != addr[p0_idx])) begin
          p1_vld = 1'b1;
          p1_idx = order[k];
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (active && p0_vld) gnt[p0_idx] = 1'b1;
    if (active && p1_vld) gnt[p1_idx] = 1'b1;
  end

`ifdef REGARB_PC_GUARD_EN
  assign p0_bad = (p0_idx != '0) && (addr[p0_idx] == PC_A);
  assign p1_bad = (p1_idx != '0) && (addr[p1_idx] == PC_A);
`else
  assign p0_bad = 1'b0;
  assign p1_bad = 1'b0;
`endif

  assign wen0     = active && p0_vld && !p0_bad;
  assign wen1     = active && p1_vld && !p1_bad;
  assign pc_hit   = (wen0 && (addr[p0_idx] == PC_A)) || (wen1 && (addr[p1_idx] == PC_A));
  assign last_idx = p1_vld ? p1_idx : p0_idx;
  assign rr_ptr_next = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= RUN;
      rr_ptr_reg <= '0;
      write      <= 2'b00;
      wa0        <= '0;
      wa1        <= '0;
      wd0        <= '0;
      wd1        <= '0;
      stwr       <= 1'b0;
      stin       <= '0;
      pcincr     <= 1'b0;
      pc_drop    <= 1'b0;
`ifdef REGARB_PC_GUARD_EN
      pc_err     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (active && p0_vld) rr_ptr_reg <= rr_ptr_next;
      write <= {wen1, wen0};
      if (wen0) begin
        wa0 <= addr[p0_idx];
        wd0 <= data[p0_idx];
      end
      if (wen1) begin
        wa1 <= addr[p1_idx];
        wd1 <= data[p1_idx];
      end
      stwr    <= st_req && active;
      stin    <= st_data;
      pcincr  <= pc_step && active && !pc_hit;
      pc_drop <= pc_step && pc_hit;
`ifdef REGARB_PC_GUARD_EN
      pc_err  <= active && ((p0_vld && p0_bad) || (p1_vld && p1_bad));
`endif
    end
  end

`ifdef REGARB_PC_GUARD_EN
  assign busy = (state_reg != RUN) || (|write) || stwr || pcincr || pc_drop || pc_err;
`else
  assign busy = (state_reg != RUN) || (|write) || stwr || pcincr || pc_drop;
`endif

endmodule

// File: tb/tb_reg32_wr_arbiter.sv
// Directed self-checking bench for reg32_wr_arbiter: round-robin, same-address
// serialisation, status/PC sequencing, flush/halt and asynchronous reset.
module tb_reg32_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         st_req;
  logic [31:0]  st_data;
  logic         pc_step, halt, flush;
  logic [1:0]   write;
  logic [4:0]   wa0, wa1;
  logic [31:0]  wd0, wd1;
  logic         stwr;
  logic [31:0]  stin;
  logic         pcincr, pc_drop, busy;
`ifdef REGARB_PC_GUARD_EN
  logic         pc_err;
`endif

  int checks   = 0;
  int failures = 0;

  reg32_wr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .st_req(st_req), .st_data(st_data), .pc_step(pc_step),
    .halt(halt), .flush(flush), .write(write), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .stwr(stwr), .stin(stin), .pcincr(pcincr),
    .pc_drop(pc_drop),
`ifdef REGARB_PC_GUARD_EN
    .pc_err(pc_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; req_addr = '0; req_data = '0;
    st_req = 0; st_data = '0; pc_step = 0; halt = 0; flush = 0;
    @(negedge clk);
    req = 4'b1111;
    #1;
    checks++;
    if ({write, stwr, pcincr, pc_drop} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000", {write, stwr, pcincr, pc_drop});
    end
    checks++;
    if ({wa0, wa1, wd0, wd1, stin} !== '0) begin
      failures++; $display("FAIL reset_data got wa0=%0d wa1=%0d wd0=%h wd1=%h stin=%h exp all 0", wa0, wa1, wd0, wd1, stin);
    end
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33); set_req(3, 5'd4, 32'h44);
    req = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0011) begin failures++; $display("FAIL rr_gnt0 got=%b exp=0011", gnt); end
    tick();
    checks++;
    if (write !== 2'b11 || wa0 !== 5'd1 || wa1 !== 5'd2 || wd0 !== 32'h11 || wd1 !== 32'h22) begin
      failures++; $display("FAIL rr_write1 got write=%b wa0=%0d wa1=%0d wd0=%h wd1=%h exp 11/1/2/11/22", write, wa0, wa1, wd0, wd1);
    end
    req = 4'b1100;
    #1;
    checks++;
    if (gnt !== 4'b1100) begin failures++; $display("FAIL rr_gnt1 got=%b exp=1100", gnt); end
    tick();
    checks++;
    if (write !== 2'b11 || wa0 !== 5'd3 || wa1 !== 5'd4 || wd0 !== 32'h33 || wd1 !== 32'h44) begin
      failures++; $display("FAIL rr_write2 got write=%b wa0=%0d wa1=%0d wd0=%h wd1=%h exp 11/3/4/33/44", write, wa0, wa1, wd0, wd1);
    end
    req = '0;
    tick();
    checks++;
    if (write !== 2'b00 || wa0 !== 5'd3 || wd1 !== 32'h44) begin
      failures++; $display("FAIL rr_idle got write=%b wa0=%0d wd1=%h exp 00/3/44 (hold)", write, wa0, wd1);
    end
  endtask

  task automatic test_same_addr();
    // One lone grant to requester 0 moves rr_ptr to 1.
    set_req(0, 5'd5, 32'h5);
    req = 4'b0001;
    tick();
    set_req(1, 5'd7, 32'hAAAA); set_req(2, 5'd7, 32'hBBBB);
    req = 4'b0110;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL same_gnt0 got=%b exp=0010", gnt); end
    tick();
    checks++;
    if (write !== 2'b01 || wa0 !== 5'd7 || wd0 !== 32'hAAAA) begin
      failures++; $display("FAIL same_write1 got write=%b wa0=%0d wd0=%h exp 01/7/AAAA", write, wa0, wd0);
    end
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL same_gnt1 got=%b exp=0100", gnt); end
    tick();
    checks++;
    if (write !== 2'b01 || wd0 !== 32'hBBBB) begin
      failures++; $display("FAIL same_write2 got write=%b wd0=%h exp 01/BBBB", write, wd0);
    end
    req = '0;
  endtask

  task automatic test_status();
    set_req(0, 5'd28, 32'hDEAD);
    req = 4'b0001; st_req = 1; st_data = 32'h55;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL st_gnt_blocked got=%b exp=0000", gnt); end
    tick();
    checks++;
    if (stwr !== 1'b1 || stin !== 32'h55 || write !== 2'b00) begin
      failures++; $display("FAIL st_write got stwr=%b stin=%h write=%b exp 1/55/00", stwr, stin, write);
    end
    st_req = 0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL st_gnt_release got=%b exp=0001", gnt); end
    tick();
    checks++;
    if (write !== 2'b01 || wa0 !== 5'd28 || wd0 !== 32'hDEAD || stwr !== 1'b0) begin
      failures++; $display("FAIL st_port_write got write=%b wa0=%0d wd0=%h stwr=%b exp 01/28/DEAD/0", write, wa0, wd0, stwr);
    end
    req = '0;
  endtask

  task automatic test_pc();
    set_req(3, 5'd31, 32'h100);
    req = 4'b1000; pc_step = 1;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin failures++; $display("FAIL pc_gnt got=%b exp=1000", gnt); end
    tick();
`ifdef REGARB_PC_GUARD_EN
    checks++;
    if (write !== 2'b00 || pcincr !== 1'b1 || pc_drop !== 1'b0 || pc_err !== 1'b1) begin
      failures++; $display("FAIL pc_guard got write=%b pcincr=%b pc_drop=%b pc_err=%b exp 00/1/0/1", write, pcincr, pc_drop, pc_err);
    end
`else
    checks++;
    if (write !== 2'b01 || wa0 !== 5'd31 || wd0 !== 32'h100 || pcincr !== 1'b0 || pc_drop !== 1'b1) begin
      failures++; $display("FAIL pc_drop got write=%b wa0=%0d wd0=%h pcincr=%b pc_drop=%b exp 01/31/100/0/1", write, wa0, wd0, pcincr, pc_drop);
    end
`endif
    req = '0;
    tick();
    checks++;
    if (pcincr !== 1'b1 || pc_drop !== 1'b0) begin
      failures++; $display("FAIL pc_incr got pcincr=%b pc_drop=%b exp 1/0", pcincr, pc_drop);
    end
    pc_step = 0;
  endtask

  task automatic test_flush_halt();
    set_req(0, 5'd9, 32'h99); set_req(1, 5'd10, 32'hA0);
    req = 4'b0011; flush = 1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL flush_gnt0 got=%b exp=0000", gnt); end
    tick();
    checks++;
    if (write !== 2'b00 || busy !== 1'b1) begin
      failures++; $display("FAIL flush_write0 got write=%b busy=%b exp 00/1", write, busy);
    end
    #1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL flush_gnt1 got=%b exp=0000", gnt); end
    tick();
    checks++;
    if (write !== 2'b00) begin failures++; $display("FAIL flush_write1 got=%b exp=00", write); end
    flush = 0;
    #1;
    checks++;
    if (gnt !== 4'b0011) begin failures++; $display("FAIL flush_resume got=%b exp=0011", gnt); end
    tick();
    checks++;
    if (write !== 2'b11 || wa0 !== 5'd9 || wa1 !== 5'd10) begin
      failures++; $display("FAIL flush_write2 got write=%b wa0=%0d wa1=%0d exp 11/9/10", write, wa0, wa1);
    end
    halt = 1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL halt_gnt got=%b exp=0000", gnt); end
    tick();
    checks++;
    if (write !== 2'b00 || busy !== 1'b1) begin
      failures++; $display("FAIL halt_write got write=%b busy=%b exp 00/1", write, busy);
    end
    halt = 0;
    #1;
    checks++;
    if (gnt !== 4'b0011) begin failures++; $display("FAIL halt_resume got=%b exp=0011", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_async_reset();
    // rr_ptr is 2 here; granting 2 then 0 leaves it at 1 before reset.
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2);
    set_req(2, 5'd3, 32'h3); set_req(3, 5'd4, 32'h4);
    req = 4'b0111; st_req = 1; st_data = 32'h77; pc_step = 1;
    @(posedge clk);
    #2;
    checks++;
    if (write !== 2'b11 || stwr !== 1'b1 || pcincr !== 1'b1) begin
      failures++; $display("FAIL arst_pre got write=%b stwr=%b pcincr=%b exp 11/1/1", write, stwr, pcincr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (write !== 2'b00 || stwr !== 1'b0 || pcincr !== 1'b0 || gnt !== 4'b0000) begin
      failures++; $display("FAIL arst_clear got write=%b stwr=%b pcincr=%b gnt=%b exp 00/0/0/0000", write, stwr, pcincr, gnt);
    end
    @(negedge clk);
    rst = 1'b1; st_req = 0; pc_step = 0; req = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0011) begin failures++; $display("FAIL arst_rrptr got=%b exp=0011", gnt); end
    tick();
    checks++;
    if (write !== 2'b11 || wa0 !== 5'd1 || wa1 !== 5'd2) begin
      failures++; $display("FAIL arst_write got write=%b wa0=%0d wa1=%0d exp 11/1/2", write, wa0, wa1);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_same_addr();
    test_status();
    test_pc();
    test_flush_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
